// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP controller.
//   state_e : DRP sequencer FSM states
//   req_e   : which requester owns the current DRP transaction
//   ADDR_*  : XADC DRP register addresses used by the sample path and host
package xadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_SAMPLE = 1'b0,
    REQ_HOST   = 1'b1
  } req_e;

  localparam logic [6:0] ADDR_VAUX6_STATUS = 7'h16;
  localparam logic [6:0] ADDR_CONFIG0      = 7'h40;
  localparam logic [6:0] ADDR_CONFIG1      = 7'h41;
  localparam logic [6:0] ADDR_CONFIG2      = 7'h42;
  localparam logic [6:0] ADDR_SEQ_CHSEL    = 7'h49;

endpackage

// File: rtl/xadc_drp_arb.sv
// Two-requester grant logic for the shared DRP.
//   clk, srst  : clock and synchronous active-high reset
//   enable     : high while the sequencer can accept a new transaction
//   sample_req : a sample read is pending
//   host_req   : the host port is requesting
//   grant_valid: a grant is made this cycle
//   grant_host : 1 = host granted, 0 = sample granted (valid with grant_valid)
// Samples normally win; after a sample grant a waiting host goes next so a
// steady EOC stream cannot starve the host.
module xadc_drp_arb (
  input  logic clk,
  input  logic srst,
  input  logic enable,
  input  logic sample_req,
  input  logic host_req,
  output logic grant_valid,
  output logic grant_host
);

  // 1 when the most recent grant went to the sample path; reset = host.
  logic last_sample_reg;

  always_comb begin
    grant_valid = enable & (sample_req | host_req);
    grant_host  = host_req & (~sample_req | last_sample_reg);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      last_sample_reg <= 1'b0;
    end else if (grant_valid) begin
      last_sample_reg <= ~grant_host;
    end
  end

endmodule

// File: rtl/xadc_drp_ctrl.sv
// XADC DRP sequencer: turns each EOC pulse into a DRP read of SAMPLE_ADDR
// and shares the DRP with a host register port.
//   clk_78MHz_i, reset_i          : clock (also XADC dclk) and sync reset
//   eoc_i                         : end-of-conversion pulse
//   host_req_i/we/addr/wdata      : host request (level, held until ack)
//   host_ack_o/err_o/rdata_o      : host completion pulse, timeout flag, read data
//   sample_o/valid/overrun/timeout: sample word and status pulses
//   drp_*                         : registered DRP master interface
module xadc_drp_ctrl
  import xadc_pkg::*;
#(
  parameter logic [6:0] SAMPLE_ADDR    = ADDR_VAUX6_STATUS,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk_78MHz_i,
  input  logic        reset_i,
  input  logic        eoc_i,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [6:0]  host_addr_i,
  input  logic [15:0] host_wdata_i,
  output logic        host_ack_o,
  output logic        host_err_o,
  output logic [15:0] host_rdata_o,
  output logic [15:0] sample_o,
  output logic        sample_valid_o,
  output logic        sample_overrun_o,
  output logic        sample_timeout_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state_reg, state_next;
  req_e               cur_req_reg, cur_req_next;
  logic               cur_we_reg, cur_we_next;
  logic               sample_pend_reg, sample_pend_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               den_reg, den_next;
  logic               dwe_reg, dwe_next;
  logic [6:0]         daddr_reg, daddr_next;
  logic [15:0]        di_reg, di_next;
  logic               ack_reg, ack_next;
  logic               err_reg, err_next;
  logic [15:0]        rdata_reg, rdata_next;
  logic [15:0]        sample_reg, sample_next;
  logic               valid_reg, valid_next;
  logic               overrun_reg, overrun_next;
  logic               timeout_reg, timeout_next;

  logic host_req_eff;
  logic grant_valid;
  logic grant_host;
  logic sample_in_flight;

  // During the ack cycle the host still holds its old request; it only
  // counts as a new request from the following cycle on.
  assign host_req_eff     = host_req_i & ~ack_reg;
  assign sample_in_flight = (state_reg != ST_IDLE) && (cur_req_reg == REQ_SAMPLE);

  xadc_drp_arb u_arb (
    .clk        (clk_78MHz_i),
    .srst       (reset_i),
    .enable     (state_reg == ST_IDLE),
    .sample_req (sample_pend_reg),
    .host_req   (host_req_eff),
    .grant_valid(grant_valid),
    .grant_host (grant_host)
  );

  always_comb begin
    state_next   = state_reg;
    cur_req_next = cur_req_reg;
    cur_we_next  = cur_we_reg;
    cnt_next     = cnt_reg;
    den_next     = 1'b0;
    dwe_next     = 1'b0;
    daddr_next   = daddr_reg;
    di_next      = di_reg;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    rdata_next   = rdata_reg;
    sample_next  = sample_reg;
    valid_next   = 1'b0;
    timeout_next = 1'b0;

    // A new EOC merges with any read still pending or in flight.
    overrun_next = eoc_i & (sample_pend_reg | sample_in_flight);

    // Set beats clear: an EOC in the grant cycle re-arms the request.
    sample_pend_next = sample_pend_reg;
    if (grant_valid && !grant_host) sample_pend_next = 1'b0;
    if (eoc_i)                      sample_pend_next = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = ST_ISSUE;
          den_next   = 1'b1;
          if (grant_host) begin
            cur_req_next = REQ_HOST;
            cur_we_next  = host_we_i;
            dwe_next     = host_we_i;
            daddr_next   = host_addr_i;
            di_next      = host_wdata_i;
          end else begin
            cur_req_next = REQ_SAMPLE;
            cur_we_next  = 1'b0;
            daddr_next   = SAMPLE_ADDR;
            di_next      = 16'h0000;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        cnt_next   = '0;
      end
      ST_WAIT: begin
        if (drp_drdy_i) begin
          state_next = ST_IDLE;
          if (cur_req_reg == REQ_HOST) begin
            ack_next = 1'b1;
            if (!cur_we_reg) rdata_next = drp_do_i;
          end else begin
            sample_next = drp_do_i;
            valid_next  = 1'b1;
          end
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
          state_next = ST_IDLE;
          if (cur_req_reg == REQ_HOST) begin
            ack_next = 1'b1;
            err_next = 1'b1;
          end else begin
            timeout_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_78MHz_i) begin
    if (reset_i) begin
      state_reg       <= ST_IDLE;
      cur_req_reg     <= REQ_HOST;
      cur_we_reg      <= 1'b0;
      sample_pend_reg <= 1'b0;
      cnt_reg         <= '0;
      den_reg         <= 1'b0;
      dwe_reg         <= 1'b0;
      daddr_reg       <= 7'h00;
      di_reg          <= 16'h0000;
      ack_reg         <= 1'b0;
      err_reg         <= 1'b0;
      rdata_reg       <= 16'h0000;
      sample_reg      <= 16'h0000;
      valid_reg       <= 1'b0;
      overrun_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cur_req_reg     <= cur_req_next;
      cur_we_reg      <= cur_we_next;
      sample_pend_reg <= sample_pend_next;
      cnt_reg         <= cnt_next;
      den_reg         <= den_next;
      dwe_reg         <= dwe_next;
      daddr_reg       <= daddr_next;
      di_reg          <= di_next;
      ack_reg         <= ack_next;
      err_reg         <= err_next;
      rdata_reg       <= rdata_next;
      sample_reg      <= sample_next;
      valid_reg       <= valid_next;
      overrun_reg     <= overrun_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign drp_den_o        = den_reg;
  assign drp_dwe_o        = dwe_reg;
  assign drp_daddr_o      = daddr_reg;
  assign drp_di_o         = di_reg;
  assign host_ack_o       = ack_reg;
  assign host_err_o       = err_reg;
  assign host_rdata_o     = rdata_reg;
  assign sample_o         = sample_reg;
  assign sample_valid_o   = valid_reg;
  assign sample_overrun_o = overrun_reg;
  assign sample_timeout_o = timeout_reg;

endmodule

// File: tb/tb_xadc_drp_ctrl.sv
// Self-checking bench for xadc_drp_ctrl: directed steps followed by a
// randomized run checked against a transaction-level model of the DRP
// sharing rules (pending/overrun bookkeeping, response timing, fields).
module tb_xadc_drp_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        eoc_i = 1'b0;
  logic        host_req_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [6:0]  host_addr_i = 7'h00;
  logic [15:0] host_wdata_i = 16'h0000;
  logic        host_ack_o, host_err_o;
  logic [15:0] host_rdata_o, sample_o;
  logic        sample_valid_o, sample_overrun_o, sample_timeout_o;
  logic        drp_den_o, drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i = 16'h0000;
  logic        drp_drdy_i = 1'b0;

  xadc_drp_ctrl #(.SAMPLE_ADDR(7'h16), .TIMEOUT_CYCLES(64)) dut (
    .clk_78MHz_i     (clk),
    .reset_i         (reset_i),
    .eoc_i           (eoc_i),
    .host_req_i      (host_req_i),
    .host_we_i       (host_we_i),
    .host_addr_i     (host_addr_i),
    .host_wdata_i    (host_wdata_i),
    .host_ack_o      (host_ack_o),
    .host_err_o      (host_err_o),
    .host_rdata_o    (host_rdata_o),
    .sample_o        (sample_o),
    .sample_valid_o  (sample_valid_o),
    .sample_overrun_o(sample_overrun_o),
    .sample_timeout_o(sample_timeout_o),
    .drp_den_o       (drp_den_o),
    .drp_dwe_o       (drp_dwe_o),
    .drp_daddr_o     (drp_daddr_o),
    .drp_di_o        (drp_di_o),
    .drp_do_i        (drp_do_i),
    .drp_drdy_i      (drp_drdy_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- model state for the engine ----------------
  bit          busy, t_host, t_we;
  int          t_den, t_drdy;
  bit          pend_m, eoc_prev;
  bit          x_sv, x_ack, x_err, x_to, x_ovr;
  logic [15:0] x_sample, x_rdata;
  bit          h_req, h_we;
  logic [6:0]  h_addr;
  logic [15:0] h_wdata;
  int          h_start, h_sdens;
  int          eoc_at[$];
  int          host_at[$];
  bit          rand_mode;
  int          lat_fixed;
  int          den_log_cyc[$];
  bit          den_log_host[$];
  int          n_sample_den, n_host_ack, n_ovr;
  logic [6:0]  host_addrs [4] = '{7'h40, 7'h41, 7'h42, 7'h49};
  int          t3_off [6] = '{2, 8, 80, 86, 158, 164};
  bit          t3_host [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int          t4_off [3] = '{2, 8, 14};
  bit          t4_host [3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled and inputs driven 1 ns
  // after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    eoc_i = 0; host_req_i = 0; host_we_i = 0; host_addr_i = 0;
    host_wdata_i = 0; drp_drdy_i = 0; drp_do_i = 0;
    reset_i = 1;
    step();
    step();
    reset_i = 0;
  endtask

  task automatic wait_den(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (drp_den_o) begin
        at = cyc;
        break;
      end
      step();
    end
    if (at < 0) chk("den_wait_timeout", drp_den_o, 1);
  endtask

  task automatic host_txn(input string tag, input bit we, input logic [6:0] addr,
                          input logic [15:0] wdata, input int lat,
                          input logic [15:0] rsp, input logic [15:0] exp_rdata);
    int c, p;
    host_req_i = 1; host_we_i = we; host_addr_i = addr; host_wdata_i = wdata;
    c = cyc;
    wait_den(p);
    chk({tag, "_den_cycle"}, p - c, 1);
    chk({tag, "_dwe"}, drp_dwe_o, we);
    chk({tag, "_daddr"}, drp_daddr_o, addr);
    chk({tag, "_di"}, drp_di_o, wdata);
    repeat (lat) step();
    drp_drdy_i = 1; drp_do_i = rsp;
    step();
    drp_drdy_i = 0;
    chk({tag, "_ack"}, host_ack_o, 1);
    chk({tag, "_err"}, host_err_o, 0);
    chk({tag, "_rdata"}, host_rdata_o, exp_rdata);
    host_req_i = 0;
    step();
    chk({tag, "_ack_pulse"}, host_ack_o, 0);
  endtask

  task automatic engine_init();
    busy = 0; pend_m = 0; eoc_prev = 0;
    x_sv = 0; x_ack = 0; x_err = 0; x_to = 0; x_ovr = 0;
    x_sample = 16'h0; x_rdata = 16'h0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_start = 0; h_sdens = 0;
    eoc_at.delete(); host_at.delete(); den_log_cyc.delete(); den_log_host.delete();
    n_sample_den = 0; n_host_ack = 0; n_ovr = 0;
  endtask

  // One cycle of model-checked operation with a DRP slave and stimulus.
  task automatic engine_cycle();
    logic [15:0] d;
    bit sden, hden, eoc, pend_now, inflight_s;
    int r;
    step();
    chk("sample_valid", sample_valid_o, x_sv);
    chk("host_ack", host_ack_o, x_ack);
    chk("host_err", host_err_o, x_err);
    chk("sample_timeout", sample_timeout_o, x_to);
    chk("sample_overrun", sample_overrun_o, x_ovr);
    chk("sample_word", sample_o, x_sample);
    chk("host_rdata", host_rdata_o, x_rdata);
    if (sample_overrun_o) n_ovr++;
    x_sv = 0; x_ack = 0; x_err = 0; x_to = 0; x_ovr = 0;

    sden = 0; hden = 0;
    if (busy) begin
      chk("den_during_txn", drp_den_o, 0);
    end else if (drp_den_o) begin
      if (drp_daddr_o == 7'h16) begin
        sden = 1;
        n_sample_den++;
        chk("spurious_sample_den", drp_den_o & ~pend_m, 0);
        chk("sample_dwe", drp_dwe_o, 0);
        chk("sample_di", drp_di_o, 0);
        if (h_req && cyc > h_start + 1) begin
          h_sdens++;
          chk("host_starved", h_sdens > 1, 0);
        end
      end else begin
        hden = 1;
        chk("spurious_host_den", drp_den_o & ~h_req, 0);
        chk("host_dwe", drp_dwe_o, h_we);
        chk("host_daddr", drp_daddr_o, h_addr);
        chk("host_di", drp_di_o, h_wdata);
      end
      busy = 1; t_den = cyc; t_host = hden; t_we = hden ? h_we : 1'b0;
      den_log_cyc.push_back(cyc); den_log_host.push_back(hden);
      if (lat_fixed > 0) begin
        t_drdy = cyc + lat_fixed;
      end else begin
        r = $urandom_range(0, 15);
        if (r == 0)      t_drdy = -1;
        else if (r == 1) t_drdy = cyc + 65;
        else             t_drdy = cyc + $urandom_range(1, 6);
      end
    end

    pend_now   = eoc_prev | (pend_m & ~sden);
    inflight_s = busy & ~t_host;

    drp_drdy_i = 0;
    drp_do_i   = 16'($urandom);
    if (busy && t_drdy == cyc) begin
      d = 16'($urandom);
      drp_drdy_i = 1; drp_do_i = d; busy = 0;
      if (t_host) begin
        x_ack = 1;
        if (!t_we) x_rdata = d;
      end else begin
        x_sv = 1; x_sample = d;
      end
    end else if (busy && t_drdy < 0 && cyc == t_den + 65) begin
      busy = 0;
      if (t_host) begin
        x_ack = 1; x_err = 1;
      end else begin
        x_to = 1;
      end
    end

    if (rand_mode) begin
      eoc = !eoc_prev && ($urandom_range(0, 19) == 0);
    end else begin
      eoc = (eoc_at.size() > 0) && (eoc_at[0] == cyc);
      if (eoc) void'(eoc_at.pop_front());
    end
    eoc_i    = eoc;
    x_ovr    = eoc & (pend_now | inflight_s);
    pend_m   = pend_now;
    eoc_prev = eoc;

    if (host_ack_o) begin
      h_req = 0;
      n_host_ack++;
    end else if (!h_req) begin
      if (rand_mode) begin
        h_req = ($urandom_range(0, 9) == 0);
      end else if (host_at.size() > 0 && host_at[0] <= cyc) begin
        h_req = 1;
        void'(host_at.pop_front());
      end
      if (h_req) begin
        h_we = 1'($urandom);
        h_addr = host_addrs[$urandom_range(0, 3)];
        h_wdata = 16'($urandom);
        h_start = cyc; h_sdens = 0;
      end
    end else if (cyc - h_start > 500) begin
      chk("host_ack_wait_bound", host_ack_o, 1);
      h_req = 0;
    end
    host_req_i = h_req; host_we_i = h_we; host_addr_i = h_addr; host_wdata_i = h_wdata;
  endtask

  initial begin
    int e, p, b, q;

    // ---- reset state ----
    reset_i = 1;
    step();
    step();
    chk("rst_drp", {drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o}, 0);
    chk("rst_host", {host_ack_o, host_err_o, host_rdata_o}, 0);
    chk("rst_sample", {sample_o, sample_valid_o, sample_overrun_o, sample_timeout_o}, 0);
    do_reset();
    step();

    // ---- single EOC, drdy four cycles after den ----
    eoc_i = 1; e = cyc;
    step();
    eoc_i = 0;
    wait_den(p);
    chk("t1_den_latency", p - e, 2);
    chk("t1_daddr", drp_daddr_o, 7'h16);
    chk("t1_dwe", drp_dwe_o, 0);
    chk("t1_di", drp_di_o, 0);
    step();
    chk("t1_den_one_cycle", drp_den_o, 0);
    repeat (3) step();
    drp_drdy_i = 1; drp_do_i = 16'h8A30;
    step();
    drp_drdy_i = 0;
    chk("t1_valid_cycle", cyc - p, 5);
    chk("t1_sample_valid", sample_valid_o, 1);
    chk("t1_sample", sample_o, 16'h8A30);
    chk("t1_no_host_ack", host_ack_o, 0);
    step();
    chk("t1_valid_pulse", sample_valid_o, 0);
    chk("t1_sample_held", sample_o, 16'h8A30);

    // ---- host read, then host write leaving rdata untouched ----
    host_txn("t2_read", 1'b0, 7'h42, 16'h0000, 3, 16'h1234, 16'h1234);
    host_txn("t2_write", 1'b1, 7'h41, 16'h2000, 2, 16'hBEEF, 16'h1234);

    // ---- host read timeout, late drdy ignored ----
    host_req_i = 1; host_we_i = 0; host_addr_i = 7'h40; host_wdata_i = 0;
    q = cyc;
    wait_den(p);
    chk("t5_den_cycle", p - q, 1);
    while (cyc < p + 65) step();
    chk("t5_no_early_ack", host_ack_o, 0);
    step();
    chk("t5_ack", host_ack_o, 1);
    chk("t5_err", host_err_o, 1);
    chk("t5_rdata_kept", host_rdata_o, 16'h1234);
    host_req_i = 0;
    step();
    step();
    drp_drdy_i = 1; drp_do_i = 16'hFFFF;
    step();
    drp_drdy_i = 0;
    chk("t5_late_drdy_ack", host_ack_o, 0);
    chk("t5_late_drdy_valid", sample_valid_o, 0);
    chk("t5_late_rdata", host_rdata_o, 16'h1234);
    step();
    chk("t5_late_no_den", drp_den_o, 0);

    // ---- reset while waiting for a sample response ----
    eoc_i = 1;
    step();
    eoc_i = 0;
    wait_den(p);
    step();
    step();
    reset_i = 1;
    step();
    reset_i = 0;
    chk("t6_rst_drp", {drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o}, 0);
    chk("t6_rst_host", {host_ack_o, host_err_o, host_rdata_o}, 0);
    chk("t6_rst_sample", {sample_o, sample_valid_o, sample_overrun_o, sample_timeout_o}, 0);
    step();
    drp_drdy_i = 1; drp_do_i = 16'h7777;
    step();
    drp_drdy_i = 0;
    chk("t6_stale_drdy_valid", sample_valid_o, 0);
    chk("t6_stale_drdy_ack", host_ack_o, 0);
    eoc_i = 1; e = cyc;
    step();
    eoc_i = 0;
    wait_den(p);
    chk("t6_new_den_latency", p - e, 2);
    repeat (3) step();
    drp_drdy_i = 1; drp_do_i = 16'h5A5A;
    step();
    drp_drdy_i = 0;
    chk("t6_new_valid", sample_valid_o, 1);
    chk("t6_new_sample", sample_o, 16'h5A5A);

    // ---- periodic EOC with held host reads ----
    do_reset();
    engine_init();
    rand_mode = 0; lat_fixed = 4;
    b = cyc + 5;
    eoc_at = '{b, b + 78, b + 156};
    host_at = '{b + 1, b + 79, b + 157};
    while (cyc < b + 200) engine_cycle();
    chk("t3_den_count", den_log_cyc.size(), 6);
    for (int i = 0; i < 6 && i < den_log_cyc.size(); i++) begin
      chk("t3_den_cycle", den_log_cyc[i] - b, t3_off[i]);
      chk("t3_den_owner", den_log_host[i], t3_host[i]);
    end
    chk("t3_overruns", n_ovr, 0);
    chk("t3_host_acks", n_host_ack, 3);

    // ---- overrun merge and host alternation ----
    do_reset();
    engine_init();
    rand_mode = 0; lat_fixed = 4;
    b = cyc + 5;
    eoc_at = '{b, b + 4};
    host_at = '{b + 3};
    while (cyc < b + 60) engine_cycle();
    chk("t4_den_count", den_log_cyc.size(), 3);
    for (int i = 0; i < 3 && i < den_log_cyc.size(); i++) begin
      chk("t4_den_cycle", den_log_cyc[i] - b, t4_off[i]);
      chk("t4_den_owner", den_log_host[i], t4_host[i]);
    end
    chk("t4_overruns", n_ovr, 1);

    // ---- randomized traffic ----
    do_reset();
    engine_init();
    rand_mode = 1; lat_fixed = 0;
    repeat (3000) engine_cycle();
    rand_mode = 0;
    repeat (150) engine_cycle();
    chk("rand_sample_reads_seen", n_sample_den > 0, 1);
    chk("rand_host_acks_seen", n_host_ack > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
